// File: rtl/scene_pkg.sv
// Shared constants and types for the scene sequencer: scene codes, idle code,
// FSM states and the pixel width used by every scene module.
package scene_pkg;

  localparam logic [3:0] STATE_IDLE   = 4'hA;
  localparam logic [3:0] SCENE_MENU   = 4'd0;
  localparam logic [3:0] SCENE_PLAY   = 4'd1;
  localparam logic [3:0] SCENE_RESULT = 4'd2;

  localparam int unsigned PIXEL_W = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN
  } fsm_e;

  // Scenes wrap from the last one back to the menu.
  function automatic logic [3:0] next_scene(input logic [3:0] cur, input int unsigned num);
    return (32'(cur) == num - 1) ? 4'd0 : cur + 4'd1;
  endfunction

endpackage

// File: rtl/frame_start_detect.sv
// Frame-start strobe: high while the raster position is the top-left pixel (0,0).
module frame_start_detect (
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic        frame_start_out
);

  assign frame_start_out = (hcount_in == 11'd0) && (vcount_in == 10'd0);

endmodule

// File: rtl/scene_sequencer.sv
// Scene controller: steps menu/play/result through an idle-code blanking frame and muxes
// the active scene's pixel. Optional per-scene watchdog under SCENE_WATCHDOG_EN.
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int unsigned NUM_SCENES     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 65000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [10:0]                   hcount_in,
  input  logic [9:0]                    vcount_in,
  input  logic                          start_in,
  input  logic                          abort_in,
  input  logic [NUM_SCENES-1:0]         finished_in,
  input  logic [NUM_SCENES-1:0]         busy_in,
  input  logic [PIXEL_W*NUM_SCENES-1:0] pixel_in,
  output logic [3:0]                    state_out,
  output logic                          scene_start_out,
  output logic [PIXEL_W-1:0]            pixel_out,
  output logic [7:0]                    rounds_out,
  output logic                          timeout_out
);

  fsm_e               fsm_q, fsm_d;
  logic [3:0]         code_q, code_d;
  logic [3:0]         pending_q, pending_d;
  logic [3:0]         prev_q, prev_d;
  logic               prev_vld_q, prev_vld_d;
  logic               start_q, start_d;
  logic [PIXEL_W-1:0] pixel_q, pixel_d;
  logic [7:0]         rounds_q, rounds_d;
  logic               frame_start;
  logic               cur_fin;
  logic               prev_busy;
  logic               wd_expire;

  frame_start_detect u_frame_start_detect (
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .frame_start_out (frame_start)
  );

  function automatic logic [PIXEL_W-1:0] pick_pixel(input logic [3:0] code);
    logic [PIXEL_W-1:0] pix;
    pix = '0;
    for (int i = 0; i < int'(NUM_SCENES); i++) begin
      if (code == 4'(i)) pix = pixel_in[PIXEL_W*i +: PIXEL_W];
    end
    return pix;
  endfunction

  always_comb begin
    cur_fin   = 1'b0;
    prev_busy = 1'b0;
    for (int i = 0; i < int'(NUM_SCENES); i++) begin
      if (code_q == 4'(i)) cur_fin = finished_in[i];
      if (prev_q == 4'(i)) prev_busy = busy_in[i];
    end
  end

`ifdef SCENE_WATCHDOG_EN
  logic [31:0] wd_q;
  logic        timeout_q, timeout_d;

  assign wd_expire = (fsm_q == S_RUN) && (wd_q == 32'(TIMEOUT_CYCLES - 1));

  // Zero on every non-RUN cycle, so each scene entry starts counting from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= (fsm_q == S_RUN) ? wd_q + 32'd1 : 32'd0;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    timeout_d = timeout_q;
    if (!abort_in && wd_expire) timeout_d = 1'b1;
  end

  assign timeout_out = timeout_q;
`else
  assign wd_expire   = 1'b0;
  // Parameter stays referenced so both builds share one interface.
  assign timeout_out = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  always_comb begin
    fsm_d      = fsm_q;
    code_d     = code_q;
    pending_d  = pending_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    start_d    = 1'b0;
    rounds_d   = rounds_q;

    if (abort_in) begin
      fsm_d     = S_IDLE;
      code_d    = STATE_IDLE;
      pending_d = SCENE_MENU;
    end else begin
      unique case (fsm_q)
        S_IDLE: begin
          if (start_in) begin
            pending_d  = SCENE_MENU;
            prev_vld_d = 1'b0;
            fsm_d      = S_ARM;
          end
        end
        S_ARM: begin
          if (frame_start && !(prev_vld_q && prev_busy)) begin
            code_d  = pending_q;
            start_d = 1'b1;
            fsm_d   = S_RUN;
          end
        end
        S_RUN: begin
          if (cur_fin || wd_expire) begin
            pending_d  = next_scene(code_q, NUM_SCENES);
            prev_d     = code_q;
            prev_vld_d = 1'b1;
            code_d     = STATE_IDLE;
            fsm_d      = S_ARM;
            if (32'(code_q) == NUM_SCENES - 1) rounds_d = rounds_q + 8'd1;
          end
        end
        default: begin
          fsm_d  = S_IDLE;
          code_d = STATE_IDLE;
        end
      endcase
    end

    // Blank whenever the next cycle is not inside a running scene.
    pixel_d = (fsm_d == S_RUN) ? pick_pixel(code_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= S_IDLE;
      code_q     <= STATE_IDLE;
      pending_q  <= SCENE_MENU;
      prev_q     <= SCENE_MENU;
      prev_vld_q <= 1'b0;
      start_q    <= 1'b0;
      pixel_q    <= '0;
      rounds_q   <= '0;
    end else begin
      fsm_q      <= fsm_d;
      code_q     <= code_d;
      pending_q  <= pending_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      start_q    <= start_d;
      pixel_q    <= pixel_d;
      rounds_q   <= rounds_d;
    end
  end

  assign state_out       = code_q;
  assign scene_start_out = start_q;
  assign pixel_out       = pixel_q;
  assign rounds_out      = rounds_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed self-checking bench for scene_sequencer; watchdog checks follow SCENE_WATCHDOG_EN.
module tb_scene_sequencer;

  logic        clk;
  logic        rst_n;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        start_in;
  logic        abort_in;
  logic [2:0]  finished_in;
  logic [2:0]  busy_in;
  logic [35:0] pixel_in;
  logic [3:0]  state_out;
  logic        scene_start_out;
  logic [11:0] pixel_out;
  logic [7:0]  rounds_out;
  logic        timeout_out;

  int checks = 0;
  int failures = 0;

  scene_sequencer #(
    .NUM_SCENES     (3),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .start_in        (start_in),
    .abort_in        (abort_in),
    .finished_in     (finished_in),
    .busy_in         (busy_in),
    .pixel_in        (pixel_in),
    .state_out       (state_out),
    .scene_start_out (scene_start_out),
    .pixel_out       (pixel_out),
    .rounds_out      (rounds_out),
    .timeout_out     (timeout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scene i shows {i+1, hcount[7:0]} so the source scene and column are both visible.
  function automatic logic [11:0] pix(input int scene, input logic [10:0] h);
    return {4'(scene + 1), h[7:0]};
  endfunction

  task automatic drive(input logic [10:0] h, input logic [9:0] v);
    hcount_in = h;
    vcount_in = v;
    pixel_in  = {pix(2, h), pix(1, h), pix(0, h)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    drive(11'd0, 10'd0);
    tick();
    drive(11'd1, 10'd0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_loop();
    for (int s = 0; s < 3; s++) begin
      finished_in = 3'b001 << s;
      tick();
      finished_in = 3'b000;
      frame();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start_in    = 1'b0;
    abort_in    = 1'b0;
    finished_in = 3'b000;
    busy_in     = 3'b000;
    drive(11'd5, 10'd100);
    tick();
    tick();
    check("rst_state", 32'(state_out), 32'hA);
    check("rst_pixel", 32'(pixel_out), 32'h0);
    check("rst_sstart", 32'(scene_start_out), 32'h0);
    check("rst_rounds", 32'(rounds_out), 32'h0);
    check("rst_timeout", 32'(timeout_out), 32'h0);
    rst_n = 1'b1;
    tick();

    // Start mid-frame: idle code holds until the next (0,0)
    drive(11'd10, 10'd100);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    check("arm_hold0", 32'(state_out), 32'hA);
    drive(11'd11, 10'd100);
    tick();
    check("arm_hold1", 32'(state_out), 32'hA);
    check("arm_pixel", 32'(pixel_out), 32'h0);
    frame();
    check("menu_enter", 32'(state_out), 32'h0);
    check("menu_sstart", 32'(scene_start_out), 32'h1);
    tick();
    check("sstart_width", 32'(scene_start_out), 32'h0);
    check("menu_pix1", 32'(pixel_out), 32'(pix(0, 11'd1)));
    drive(11'd2, 10'd0);
    tick();
    check("menu_pix2", 32'(pixel_out), 32'(pix(0, 11'd2)));

    // Non-current finished and start outside idle are ignored
    finished_in = 3'b100;
    tick();
    finished_in = 3'b000;
    check("ignore_fin", 32'(state_out), 32'h0);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    check("ignore_start", 32'(state_out), 32'h0);
    check("ignore_sstart", 32'(scene_start_out), 32'h0);

    // MENU -> PLAY
    finished_in = 3'b001;
    tick();
    finished_in = 3'b000;
    check("menu_fin", 32'(state_out), 32'hA);
    frame();
    check("play_enter", 32'(state_out), 32'h1);
    check("play_sstart", 32'(scene_start_out), 32'h1);
    drive(11'd3, 10'd0);
    tick();
    check("play_pix", 32'(pixel_out), 32'(pix(1, 11'd3)));

    // PLAY finishes while still busy: two frame starts are skipped
    finished_in = 3'b010;
    busy_in     = 3'b010;
    tick();
    finished_in = 3'b000;
    check("play_fin", 32'(state_out), 32'hA);
    check("play_fin_pix", 32'(pixel_out), 32'h0);
    frame();
    check("busy_hold1", 32'(state_out), 32'hA);
    check("busy_nostart", 32'(scene_start_out), 32'h0);
    drive(11'd5, 10'd5);
    tick();
    frame();
    check("busy_hold2", 32'(state_out), 32'hA);
    busy_in = 3'b000;
    drive(11'd7, 10'd7);
    tick();
    check("busy_drop", 32'(state_out), 32'hA);
    frame();
    check("result_enter", 32'(state_out), 32'h2);
    check("rounds_pre", 32'(rounds_out), 32'h0);

    // RESULT completes one round and wraps to MENU
    finished_in = 3'b100;
    tick();
    finished_in = 3'b000;
    check("result_fin", 32'(state_out), 32'hA);
    check("rounds_inc", 32'(rounds_out), 32'h1);
    frame();
    check("wrap_menu", 32'(state_out), 32'h0);

    // Abort beats a simultaneous finished
    abort_in    = 1'b1;
    finished_in = 3'b001;
    tick();
    abort_in    = 1'b0;
    finished_in = 3'b000;
    check("abort_state", 32'(state_out), 32'hA);
    check("abort_rounds", 32'(rounds_out), 32'h1);
    frame();
    check("abort_idle", 32'(state_out), 32'hA);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    frame();
    check("restart", 32'(state_out), 32'h0);

`ifdef SCENE_WATCHDOG_EN
    repeat (49) tick();
    check("wd_before", 32'(state_out), 32'h0);
    check("wd_before_to", 32'(timeout_out), 32'h0);
    tick();
    check("wd_fire", 32'(state_out), 32'hA);
    check("wd_timeout", 32'(timeout_out), 32'h1);
    frame();
    check("wd_next", 32'(state_out), 32'h1);
    check("wd_sticky", 32'(timeout_out), 32'h1);
`else
    repeat (60) tick();
    check("nowd_state", 32'(state_out), 32'h0);
    check("nowd_timeout", 32'(timeout_out), 32'h0);
`endif

    // Rounds counter wraps 255 -> 0
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    frame();
    check("loop_start", 32'(state_out), 32'h0);
    repeat (254) do_loop();
    check("rounds_255", 32'(rounds_out), 32'hFF);
    check("loop_state", 32'(state_out), 32'h0);
    do_loop();
    check("rounds_wrap", 32'(rounds_out), 32'h0);
    do_loop();
    check("rounds_after", 32'(rounds_out), 32'h1);

    // Asynchronous reset mid-scene
    drive(11'd9, 10'd0);
    tick();
    check("pre_rst_pix", 32'(pixel_out), 32'(pix(0, 11'd9)));
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state_out), 32'hA);
    check("arst_pixel", 32'(pixel_out), 32'h0);
    check("arst_rounds", 32'(rounds_out), 32'h0);
    check("arst_sstart", 32'(scene_start_out), 32'h0);
    check("arst_timeout", 32'(timeout_out), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scene_sequencer.md
# scene_sequencer

Top-level scene controller that sequences the full-screen scene modules (menu, play, result) through their shared 4-bit `state_in` / `busy_out` / `finished_out` handshake. It drives the `state_out` code into every scene module and owns the single 12-bit pixel path to the video output. Scene changes commit only at frame start, with one blanking frame between scenes.

## Interface
- NUM_SCENES, 3, number of scene modules; scene i is entered when `state_out` = i
- TIMEOUT_CYCLES, 65000000, watchdog limit per scene in clk cycles (only with watchdog macro)
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- hcount_in  in  11  current pixel column
- vcount_in  in  10  current pixel row
- start_in  in  1  single-cycle request to leave idle
- abort_in  in  1  single-cycle request to return to idle
- finished_in  in  NUM_SCENES  per-scene completion pulses
- busy_in  in  NUM_SCENES  per-scene busy levels
- pixel_in  in  12*NUM_SCENES  scene pixels; scene i occupies bits [12i+11:12i]
- state_out  out  4  scene code to all scene modules
- scene_start_out  out  1  one-cycle pulse when a scene is entered
- pixel_out  out  12  registered selected pixel
- rounds_out  out  8  completed MENU→PLAY→RESULT loops, wraps at 255→0
- timeout_out  out  1  sticky flag: a scene was force-advanced

## Operation
- Idle code is 4'hA; scenes use codes 0..NUM_SCENES-1. The next scene is (cur+1) mod NUM_SCENES.
- frame_start = (hcount_in==0 && vcount_in==0).
- FSM states:
  - S_IDLE: `state_out`=4'hA, `pixel_out`=0. `start_in` sets pending=0 and moves to S_ARM.
  - S_ARM: `state_out`=4'hA, `pixel_out`=0. Waits for frame_start with `busy_in[prev]`=0, where prev is the scene just left (ignored on entry from idle). Then `state_out`←pending, `scene_start_out` pulses, and the FSM moves to S_RUN.
  - S_RUN: `pixel_out`←`pixel_in[cur]`. `finished_in[cur]` sets pending=next(cur), prev=cur, and moves to S_ARM. If cur = NUM_SCENES-1, `rounds_out` increments.
- Forcing 4'hA between scenes guarantees that every scene module sees a state edge on entry.
- `finished_in` bits of non-current scenes are ignored.
- `start_in` outside S_IDLE is ignored.
- `abort_in` in any state goes to S_IDLE and clears pending. It wins over a simultaneous finished or frame_start. It does not clear `rounds_out` or `timeout_out`.
- `busy_in[prev]` still high at frame_start: stay in S_ARM and retry at the next frame_start.

## Timing
- Reset values: FSM=S_IDLE, `state_out`=4'hA, `pixel_out`=0, `scene_start_out`=0, `rounds_out`=0, `timeout_out`=0.
- All outputs are registered.
- `pixel_out` lags `hcount_in`/`vcount_in` by 1 cycle.
- A transition committed on a frame_start edge shows on `state_out` and `scene_start_out` in the following cycle.
- `finished_in` → `state_out`=4'hA: 1 cycle. The new scene code then appears at the next qualifying frame_start.
- `scene_start_out` is exactly 1 cycle wide.
- Reset asserted mid-scene returns all outputs to reset values immediately (asynchronous assertion). Deassertion is synchronous to clk.

## Configuration
- SCENE_WATCHDOG_EN defined:
  - A 32-bit counter clears on S_RUN entry and increments every S_RUN cycle.
  - Reaching TIMEOUT_CYCLES-1 acts as `finished_in[cur]` and sets `timeout_out`.
  - `timeout_out` stays set until reset.
  - `abort_in` in the same cycle still wins.
- SCENE_WATCHDOG_EN undefined: no counter, `timeout_out` tied 0, TIMEOUT_CYCLES unused.

## Structure
- Package `scene_pkg`:
  - STATE_IDLE=4'hA, scene codes SCENE_MENU=0, SCENE_PLAY=1, SCENE_RESULT=2
  - FSM enum {S_IDLE, S_ARM, S_RUN}
  - pixel width constant 12
- Sub-module `frame_start_detect`: compares hcount/vcount against (0,0) and produces the frame_start strobe.

## Test plan
- Reset, then `start_in` at vcount=100 → `state_out` stays 4'hA until the next (0,0), then becomes 0 with a 1-cycle `scene_start_out`; `pixel_out` equals `pixel_in[0]` one cycle after each pixel.
- In PLAY, pulse `finished_in[1]` → `state_out`=4'hA next cycle and `pixel_out`=0; `state_out`=2 after the next frame_start.
- Complete RESULT (`finished_in[2]`) → `rounds_out` 0→1 and the scene returns to 0 through 4'hA. Preload 255 loops → `rounds_out` wraps to 0.
- `busy_in[1]` held high across two frame_starts after PLAY finishes → `state_out` stays 4'hA; drop it → `state_out`=2 at the following frame_start.
- `abort_in` and `finished_in[cur]` in the same cycle → S_IDLE, `state_out`=4'hA, `rounds_out` unchanged. `finished_in[2]` while cur=0 → no effect.
- SCENE_WATCHDOG_EN with TIMEOUT_CYCLES=50 and no finished pulse → advance after 50 S_RUN cycles with `timeout_out`=1. Without the macro → `timeout_out` stays 0 and the scene never advances.
